// File: rtl/stream_channel_demux_pkg.sv
// Shared types and default parameters for the stream channel demultiplexer.
// The helper sizes index registers so that a count of one still gets a 1-bit field.
package stream_channel_demux_pkg;

  typedef enum logic [1:0] {
    ST_TAG  = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_CH      = 2;
  localparam int unsigned DEF_ADDR_BYTES  = 3;
  localparam int unsigned DEF_TRAIL_BYTES = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_channel_demux_trail_buffer.sv
// Fixed-depth byte shift register that holds back the trailing FCS bytes.
// With depth 0 it is a wire: always full, and out follows the incoming byte.
module stream_channel_demux_trail_buffer
  import stream_channel_demux_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_TRAIL_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       clear,
  input  logic [7:0] din,
  output logic       full,
  output logic [7:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign full = 1'b1;
    assign dout = din;

    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, push, clear};
  end else begin : g_shift
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       mem [DEPTH];
    logic [CNT_W-1:0] cnt_q;

    // NOTE: the byte storage is reset along with the fill count so that a
    // reset leaves no stale FCS bytes that a later packet could expose.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (clear) begin
        cnt_q <= '0;
      end else if (push) begin
        for (int i = int'(DEPTH) - 1; i > 0; i--) mem[i] <= mem[i-1];
        mem[0] <= din;
        if (cnt_q != CNT_W'(DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    // Oldest byte sits at the far end; it is what a push displaces.
    assign full = (cnt_q == CNT_W'(DEPTH));
    assign dout = mem[DEPTH-1];
  end

endmodule

// File: rtl/stream_channel_demux.sv
// Reassembles bytes from a dibit stream, decodes tag and base address headers,
// and routes payload bytes (minus trailing FCS) to one of NUM_CH channels.
module stream_channel_demux
  import stream_channel_demux_pkg::*;
#(
  parameter  int unsigned NUM_CH      = DEF_NUM_CH,
  parameter  int unsigned ADDR_BYTES  = DEF_ADDR_BYTES,
  parameter  int unsigned TRAIL_BYTES = DEF_TRAIL_BYTES,
  localparam int unsigned ADDR_W      = 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [1:0]        axiid,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [NUM_CH-1:0] ch_valid,
  output logic [NUM_CH-1:0] ch_done,
  output logic              pkt_err
);

  localparam int unsigned TAG_W = idx_w(NUM_CH);
  localparam int unsigned AC_W  = idx_w(ADDR_BYTES);

  state_t            state_q, state_d;
  logic              armed_q;
  logic [1:0]        dibit_cnt_q;
  logic [5:0]        byte_sr_q;
  logic [AC_W-1:0]   addr_cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] index_q;
  logic [TAG_W-1:0]  tag_q;

  logic [7:0]        cur_byte;
  logic              active;
  logic              byte_done;
  logic [NUM_CH-1:0] tag_onehot;

  logic              push;
  logic              clear;
  logic              emit;
  logic              latch_tag;
  logic              shift_addr;
  logic              err_d;
  logic              done_d;
  logic              buf_full;
  logic [7:0]        buf_out;

  // After reset the input is ignored until the first idle cycle, so a packet
  // that was already in flight cannot be mistaken for a fresh header.
  assign active     = armed_q & axiiv;
  assign cur_byte   = {byte_sr_q, axiid};
  assign byte_done  = active & (dibit_cnt_q == 2'd3);
  assign tag_onehot = NUM_CH'(1) << tag_q;

  stream_channel_demux_trail_buffer #(
    .DEPTH (TRAIL_BYTES)
  ) u_trail_buffer (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .clear (clear),
    .din   (cur_byte),
    .full  (buf_full),
    .dout  (buf_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_TAG;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    clear      = 1'b0;
    emit       = 1'b0;
    latch_tag  = 1'b0;
    shift_addr = 1'b0;
    err_d      = 1'b0;
    done_d     = 1'b0;

    if (armed_q && !axiiv) begin
      unique case (state_q)
        ST_TAG:  err_d = (dibit_cnt_q != 2'd0);
        ST_ADDR: err_d = 1'b1;
        ST_DATA: begin
          done_d = (dibit_cnt_q == 2'd0) && buf_full;
          err_d  = !done_d;
        end
        ST_DROP: ;
      endcase
      state_d = ST_TAG;
      clear   = 1'b1;
    end else if (byte_done) begin
      unique case (state_q)
        ST_TAG: begin
          if ({24'd0, cur_byte} < NUM_CH) begin
            latch_tag = 1'b1;
            state_d   = ST_ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
        ST_ADDR: begin
          shift_addr = 1'b1;
          if (addr_cnt_q == AC_W'(ADDR_BYTES - 1)) state_d = ST_DATA;
        end
        ST_DATA: begin
          push = 1'b1;
          emit = buf_full;
        end
        ST_DROP: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q     <= 1'b0;
      dibit_cnt_q <= '0;
      byte_sr_q   <= '0;
      addr_cnt_q  <= '0;
      base_q      <= '0;
      index_q     <= '0;
      tag_q       <= '0;
      data_out    <= '0;
      addr_out    <= '0;
      ch_valid    <= '0;
      ch_done     <= '0;
      pkt_err     <= 1'b0;
    end else begin
      armed_q  <= armed_q | ~axiiv;
      ch_valid <= '0;
      ch_done  <= done_d ? tag_onehot : '0;
      pkt_err  <= err_d;

      if (clear) begin
        dibit_cnt_q <= '0;
        addr_cnt_q  <= '0;
        index_q     <= '0;
      end else if (active) begin
        dibit_cnt_q <= dibit_cnt_q + 2'd1;
        byte_sr_q   <= cur_byte[5:0];
      end

      if (latch_tag) tag_q <= cur_byte[TAG_W-1:0];

      if (shift_addr) begin
        base_q     <= (base_q << 8) | ADDR_W'(cur_byte);
        addr_cnt_q <= addr_cnt_q + AC_W'(1);
      end

      // Address wraps naturally at ADDR_W bits.
      if (emit) begin
        data_out <= buf_out;
        addr_out <= base_q + index_q;
        ch_valid <= tag_onehot;
        index_q  <= index_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_channel_demux.sv
// Randomised and directed bench for stream_channel_demux (2 channels, 3-byte
// address, 4 FCS bytes) against a packet-level event model.
module tb_stream_channel_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        axiiv = 1'b0;
  logic [1:0]  axiid = 2'b00;
  logic [7:0]  data_out;
  logic [23:0] addr_out;
  logic [1:0]  ch_valid;
  logic [1:0]  ch_done;
  logic        pkt_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef logic [7:0] bytes_t [$];
  logic [63:0] obs_q [$];
  logic [63:0] exp_q [$];

  stream_channel_demux #(
    .NUM_CH      (2),
    .ADDR_BYTES  (3),
    .TRAIL_BYTES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .axiiv    (axiiv),
    .axiid    (axiid),
    .data_out (data_out),
    .addr_out (addr_out),
    .ch_valid (ch_valid),
    .ch_done  (ch_done),
    .pkt_err  (pkt_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event word: edge number, kind (0 byte, 1 done, 2 error), channel vector, data, address.
  function automatic logic [63:0] ev(input int c, input logic [1:0] kind, input logic [1:0] ch,
                                     input logic [7:0] d, input logic [23:0] a);
    logic [31:0] cv;
    cv = c;
    return {cv[27:0], kind, ch, d, a};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (ch_valid != 2'b00) obs_q.push_back(ev(cyc, 2'd0, ch_valid, data_out, addr_out));
      if (ch_done != 2'b00)  obs_q.push_back(ev(cyc, 2'd1, ch_done, 8'h00, 24'h0));
      if (pkt_err)           obs_q.push_back(ev(cyc, 2'd2, 2'b00, 8'h00, 24'h0));
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected events for one packet whose first dibit is sampled on edge e0.
  // Byte j ends on edge e0+4j+3; payload byte k leaves when byte 4+k+4 ends.
  task automatic model(input bytes_t b, input int stray, input int e0, input bit no_end);
    int          len;
    int          ndib;
    int          p;
    logic [23:0] base;
    logic [1:0]  oh;
    logic [7:0]  tg;
    len  = b.size();
    ndib = 4 * len + stray;
    if (len == 0) begin
      if (!no_end && stray > 0) exp_q.push_back(ev(e0 + ndib, 2'd2, 2'b00, 8'h00, 24'h0));
      return;
    end
    tg = b[0];
    if (tg >= 8'd2) begin
      exp_q.push_back(ev(e0 + 3, 2'd2, 2'b00, 8'h00, 24'h0));
      return;
    end
    oh = (tg == 8'd0) ? 2'b01 : 2'b10;
    if (len < 4) begin
      if (!no_end) exp_q.push_back(ev(e0 + ndib, 2'd2, 2'b00, 8'h00, 24'h0));
      return;
    end
    base = {b[1], b[2], b[3]};
    p    = len - 4;
    for (int k = 0; k < p - 4; k++)
      exp_q.push_back(ev(e0 + 4 * (8 + k) + 3, 2'd0, oh, b[4+k], base + 24'(k)));
    if (!no_end) begin
      if (stray == 0 && p >= 4) exp_q.push_back(ev(e0 + ndib, 2'd1, oh, 8'h00, 24'h0));
      else                      exp_q.push_back(ev(e0 + ndib, 2'd2, 2'b00, 8'h00, 24'h0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bytes(input bytes_t b, input int stray, output int e0);
    logic [7:0] t;
    e0 = -1;
    foreach (b[i]) begin
      t = b[i];
      for (int k = 0; k < 4; k++) begin
        step();
        if (e0 < 0) e0 = cyc + 1;
        axiiv = 1'b1;
        axiid = t[7-2*k -: 2];
      end
    end
    for (int s = 0; s < stray; s++) begin
      step();
      if (e0 < 0) e0 = cyc + 1;
      axiiv = 1'b1;
      axiid = 2'($urandom);
    end
  endtask

  task automatic send(input bytes_t b, input int stray, input int idle);
    int e0;
    drive_bytes(b, stray, e0);
    if (e0 >= 0) model(b, stray, e0, 1'b0);
    repeat (idle) begin
      step();
      axiiv = 1'b0;
      axiid = 2'($urandom);
    end
  endtask

  task automatic settle_compare(input string tag);
    int n;
    repeat (4) begin
      step();
      axiiv = 1'b0;
    end
    @(negedge clk);
    #1;
    check($sformatf("%s_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bytes_t b;
    int     e0;
    int     p;

    #1;
    check("reset_outputs", {27'd0, data_out, addr_out, ch_valid, ch_done, pkt_err}, 64'd0);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();

    send('{8'h01, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33, 8'h44}, 0, 2);
    settle_compare("pkt_ch1");

    b = '{8'h05};
    for (int i = 0; i < 10; i++) b.push_back(8'($urandom));
    send(b, 0, 1);
    settle_compare("bad_tag");

    send('{8'h00, 8'h12, 8'h34}, 0, 1);
    settle_compare("short_header");

    send('{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'h5B, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0, 1);
    settle_compare("addr_wrap");

    send('{8'h01, 8'h00, 8'h00, 8'h40, 8'h10, 8'h20, 8'h30, 8'hF1, 8'hF2, 8'hF3, 8'hF4}, 2, 1);
    settle_compare("stray_dibits");

    send('{8'h00, 8'h00, 8'h02, 8'h00, 8'h71, 8'h72}, 0, 1);
    settle_compare("short_payload");

    send('{8'h00, 8'h00, 8'h00, 8'h20, 8'hC1, 8'hC2, 8'h01, 8'h02, 8'h03, 8'h04}, 0, 1);
    send('{8'h01, 8'h00, 8'h00, 8'h30, 8'hD1, 8'hD2, 8'hD3, 8'h05, 8'h06, 8'h07, 8'h08}, 0, 1);
    settle_compare("back_to_back");

    // Reset in the middle of a payload, after two bytes have been emitted.
    b = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    drive_bytes(b, 0, e0);
    model(b, 0, e0, 1'b1);
    step();
    axiid = 2'($urandom);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset_mid_clear", {27'd0, data_out, addr_out, ch_valid, ch_done, pkt_err}, 64'd0);
    repeat (2) step();
    rst = 1'b1;
    repeat (5) begin
      step();
      axiiv = 1'b1;
      axiid = 2'($urandom);
    end
    step();
    axiiv = 1'b0;
    send('{8'h01, 8'h00, 8'hAB, 8'hCD, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86}, 0, 1);
    settle_compare("reset_recover");

    for (int n = 0; n < 30; n++) begin
      b.delete();
      b.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(2, 255))
                                              : 8'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin
        p = $urandom_range(0, 2);
        for (int i = 0; i < p; i++) b.push_back(8'($urandom));
      end else begin
        p = 3 + $urandom_range(0, 10);
        for (int i = 0; i < p; i++) b.push_back(8'($urandom));
      end
      send(b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(1, 3));
      settle_compare($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
